// File: rtl/pattern_detector_counter.sv
// Serial pattern detector with masked compare, overlap control and a BCD match counter.
// Define COUNT_SATURATE_EN to hold the count at all-9s instead of wrapping to zero.
module pattern_detector_counter #(
    parameter int PAT_W  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  clr,
    input  logic                  sig_valid,
    input  logic                  sig_to_test,
    input  logic [PAT_W-1:0]      pat,
    input  logic [PAT_W-1:0]      pat_mask,
    input  logic                  overlap,
    output logic                  z,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   disp,
    output logic                  ovf
);

    localparam int              FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FULL = FW'(PAT_W);
    localparam logic [6:0]      SEG0 = 7'b1000000;

    logic [PAT_W-1:0]     r_hist;
    logic [FW-1:0]        r_fill;
    logic                 r_z;
    logic                 r_ovf;
    logic [4*DIGITS-1:0]  r_count;
    logic [7*DIGITS-1:0]  r_disp;

    logic                 w_acc;
    logic                 w_match;
    logic                 w_cout;
    logic [PAT_W-1:0]     w_win;
    logic [FW-1:0]        w_fill_inc;
    logic [FW-1:0]        w_fill_nxt;
    logic [4*DIGITS-1:0]  w_cnt_inc;
    logic [4*DIGITS-1:0]  w_cnt_nxt;
    logic [7*DIGITS-1:0]  w_seg;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b0000111;
        endcase
        return s;
    endfunction

    assign w_acc      = ena & sig_valid;
    assign w_win      = {r_hist[PAT_W-2:0], sig_to_test};
    assign w_fill_inc = (r_fill == FULL) ? FULL : r_fill + 1'b1;

    // The compare looks at the window as it will be after this sample shifts in
    assign w_match = w_acc && (w_fill_inc == FULL) &&
                     (((w_win ^ pat) & pat_mask) == '0);

    assign w_fill_nxt = (w_match && !overlap) ? '0 : w_fill_inc;

    always_comb begin
        w_cnt_inc = r_count;
        w_cout    = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_cout) begin
                if (r_count[4*d +: 4] >= 4'd9) begin
                    w_cnt_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    w_cout              = 1'b0;
                end
            end
        end
    end

`ifdef COUNT_SATURATE_EN
    assign w_cnt_nxt = w_cout ? r_count : w_cnt_inc;
`else
    assign w_cnt_nxt = w_cnt_inc;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign w_seg[7*g +: 7] = f_seg(r_count[4*g +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_z     <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_z     <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_z <= w_match;
            if (w_acc) begin
                r_hist <= w_win;
                r_fill <= w_fill_nxt;
            end
            if (w_match) begin
                r_count <= w_cnt_nxt;
                if (w_cout) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Display follows the registered count, so it trails by one enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= {DIGITS{SEG0}};
        end else if (ena) begin
            r_disp <= w_seg;
        end
    end

    assign z     = r_z;
    assign count = r_count;
    assign disp  = r_disp;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_pattern_detector_counter.sv
// Directed bench for pattern_detector_counter (PAT_W=4, DIGITS=2).
// Expected values are hand-computed; COUNT_SATURATE_EN selects the final count.
module tb_pattern_detector_counter;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        clr;
    logic        sig_valid;
    logic        sig_to_test;
    logic [3:0]  pat;
    logic [3:0]  pat_mask;
    logic        overlap;
    logic        z;
    logic [7:0]  count;
    logic [13:0] disp;
    logic        ovf;

    int n_vec;
    int n_err;

`ifdef COUNT_SATURATE_EN
    localparam logic [7:0] WRAP = 8'h99;
`else
    localparam logic [7:0] WRAP = 8'h00;
`endif

    pattern_detector_counter #(.PAT_W(4), .DIGITS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .clr         (clr),
        .sig_valid   (sig_valid),
        .sig_to_test (sig_to_test),
        .pat         (pat),
        .pat_mask    (pat_mask),
        .overlap     (overlap),
        .z           (z),
        .count       (count),
        .disp        (disp),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        @(negedge clk);
        sig_valid   = v;
        sig_to_test = b;
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input string tag, input logic b, input logic ez);
        step(1'b1, b);
        chk(tag, 32'(z), 32'(ez));
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr       = 1'b1;
        sig_valid = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        clr         = 1'b0;
        sig_valid   = 1'b0;
        sig_to_test = 1'b0;
        pat         = 4'b0101;
        pat_mask    = 4'b1111;
        overlap     = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", 32'(z), 32'h0);
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_disp", 32'(disp), 32'h2040);
        @(negedge clk);
        rst_n = 1'b1;

        // overlapping matches on 010101
        samp("ov_s1", 1'b0, 1'b0);
        samp("ov_s2", 1'b1, 1'b0);
        samp("ov_s3", 1'b0, 1'b0);
        samp("ov_s4", 1'b1, 1'b1);
        samp("ov_s5", 1'b0, 1'b0);
        samp("ov_s6", 1'b1, 1'b1);
        chk("ov_count", 32'(count), 32'h02);
        chk("ov_disp_lag", 32'(disp), 32'h2079);
        step(1'b0, 1'b0);
        chk("ov_z_idle", 32'(z), 32'h0);
        chk("ov_disp", 32'(disp), 32'h2024);

        // ena=0 blocks acceptance and freezes display
        @(negedge clk);
        ena         = 1'b0;
        sig_valid   = 1'b1;
        sig_to_test = 1'b0;
        @(posedge clk);
        #1;
        chk("ena0_z_a", 32'(z), 32'h0);
        @(negedge clk);
        sig_to_test = 1'b1;
        @(posedge clk);
        #1;
        chk("ena0_z_b", 32'(z), 32'h0);
        chk("ena0_count", 32'(count), 32'h02);
        chk("ena0_disp", 32'(disp), 32'h2024);
        @(negedge clk);
        ena       = 1'b1;
        sig_valid = 1'b0;

        // non-overlapping
        do_clr();
        chk("clr_count", 32'(count), 32'h00);
        overlap = 1'b0;
        samp("no_s1", 1'b0, 1'b0);
        samp("no_s2", 1'b1, 1'b0);
        samp("no_s3", 1'b0, 1'b0);
        samp("no_s4", 1'b1, 1'b1);
        samp("no_s5", 1'b0, 1'b0);
        samp("no_s6", 1'b1, 1'b0);
        chk("no_count", 32'(count), 32'h01);

        // masked compare
        do_clr();
        pat      = 4'b0001;
        pat_mask = 4'b1001;
        samp("mk_s1", 1'b0, 1'b0);
        samp("mk_s2", 1'b1, 1'b0);
        samp("mk_s3", 1'b1, 1'b0);
        samp("mk_s4", 1'b1, 1'b1);
        samp("mk_s5", 1'b1, 1'b0);
        samp("mk_s6", 1'b0, 1'b0);
        samp("mk_s7", 1'b0, 1'b0);
        samp("mk_s8", 1'b0, 1'b0);
        chk("mk_count", 32'(count), 32'h01);

        // clr beats a simultaneous match
        do_clr();
        pat_mask = 4'b0000;
        overlap  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
        end
        chk("cm_count5", 32'(count), 32'h05);
        pat      = 4'b0101;
        pat_mask = 4'b1111;
        samp("cm_s1", 1'b0, 1'b0);
        samp("cm_s2", 1'b1, 1'b0);
        samp("cm_s3", 1'b0, 1'b0);
        @(negedge clk);
        clr         = 1'b1;
        sig_valid   = 1'b1;
        sig_to_test = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("cm_z", 32'(z), 32'h0);
        chk("cm_count", 32'(count), 32'h00);
        chk("cm_ovf", 32'(ovf), 32'h0);
        step(1'b0, 1'b0);
        chk("cm_z_after", 32'(z), 32'h0);

        // 100 matches from zero
        pat_mask = 4'b0000;
        for (int i = 1; i <= 103; i++) begin
            step(1'b1, 1'b1);
            if (i == 13) chk("c100_carry", 32'(count), 32'h10);
            if (i == 102) begin
                chk("c100_99", 32'(count), 32'h99);
                chk("c100_ovf0", 32'(ovf), 32'h0);
            end
            if (i == 103) begin
                chk("c100_z", 32'(z), 32'h1);
                chk("c100_count", 32'(count), 32'(WRAP));
                chk("c100_ovf", 32'(ovf), 32'h1);
            end
        end

        // async reset mid-stream
        pat      = 4'b0101;
        pat_mask = 4'b1111;
        samp("ar_s1", 1'b0, 1'b0);
        samp("ar_s2", 1'b1, 1'b0);
        samp("ar_s3", 1'b0, 1'b0);
        chk("ar_ovf_pre", 32'(ovf), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_z", 32'(z), 32'h0);
        chk("ar_count", 32'(count), 32'h00);
        chk("ar_ovf", 32'(ovf), 32'h0);
        chk("ar_disp", 32'(disp), 32'h2040);
        #1;
        rst_n = 1'b1;
        samp("ar_n1", 1'b1, 1'b0);
        samp("ar_n2", 1'b0, 1'b0);
        samp("ar_n3", 1'b1, 1'b0);
        samp("ar_n4", 1'b0, 1'b0);
        samp("ar_n5", 1'b1, 1'b1);
        chk("ar_count_end", 32'(count), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
